// File: rtl/core_reset_sequencer.sv
// rtl/core_reset_sequencer.sv - staggered multi-domain reset sequencer with soft-reset handshake
//
// Releases NumOut active-low reset domains one after another after a wake-up
// delay, then reports done. A rising soft_rst_req_i while running re-asserts
// every domain, holds them for SoftHoldCycles and re-runs the staggered
// release, acknowledging with a one-cycle soft_rst_ack_o pulse.
//
// Ports:
//   clk_i           core clock
//   reset_l         asynchronous active-low reset
//   soft_rst_req_i  soft-reset request level (rising edge triggers, RUN only)
//   soft_rst_ack_o  one-cycle pulse when a soft reset sequence completes
//   rst_n_o         per-domain resets, async assert / sync deassert
//   rst_done_o      high in RUN once every domain is released
//   phase_o         FSM state for debug (WAKE=0, RELEASE=1, RUN=2, SOFT=3)
module core_reset_sequencer #(
    parameter int NumOut         = 3,
    parameter int WakeUpCycles   = 32768,
    parameter int StaggerCycles  = 16,
    parameter int SoftHoldCycles = 64,
    parameter int SyncStages     = 2,
    parameter int CntWidth       = 16
) (
    input  logic              clk_i,
    input  logic              reset_l,
    input  logic              soft_rst_req_i,
    output logic              soft_rst_ack_o,
    output logic [NumOut-1:0] rst_n_o,
    output logic              rst_done_o,
    output logic [1:0]        phase_o
);

    localparam logic [1:0] ST_WAKE    = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;
    localparam logic [1:0] ST_SOFT    = 2'd3;

    localparam int IdxW = (NumOut > 1) ? $clog2(NumOut) : 1;

    localparam logic [CntWidth-1:0] WAKE_LAST = CntWidth'(WakeUpCycles - 1);
    localparam logic [CntWidth-1:0] STAG_LAST = CntWidth'((StaggerCycles > 0) ? StaggerCycles - 1 : 0);
    localparam logic [CntWidth-1:0] SOFT_LAST = CntWidth'(SoftHoldCycles - 1);
    localparam logic [IdxW-1:0]     IDX_LAST  = IdxW'(NumOut - 1);

    // With a single domain or no stagger there is nothing to sequence.
    localparam bit ALL_AT_ONCE = (NumOut == 1) || (StaggerCycles == 0);

    if ((NumOut < 1) || (WakeUpCycles < 1) || (SoftHoldCycles < 1) || (SyncStages < 2) ||
        (StaggerCycles < 0) || (CntWidth < 1) || (CntWidth > 30) ||
        ((2 ** CntWidth) <= WakeUpCycles) || ((2 ** CntWidth) <= StaggerCycles) ||
        ((2 ** CntWidth) <= SoftHoldCycles)) begin : g_param_check
        $error("core_reset_sequencer: invalid parameter set");
    end

    logic [1:0]                          r_state;
    logic [1:0]                          w_state_nxt;
    logic [CntWidth-1:0]                 r_cnt;
    logic [CntWidth-1:0]                 w_cnt_nxt;
    logic [IdxW-1:0]                     r_idx;
    logic [IdxW-1:0]                     w_idx_nxt;
    logic [NumOut-1:0]                   r_rel;
    logic [NumOut-1:0]                   w_rel_nxt;
    logic [SyncStages-1:0][NumOut-1:0]   r_sync;
    logic                                r_req_q;
    logic                                r_soft_pend;
    logic                                w_soft_pend_nxt;
    logic                                w_sync_clr;
    logic                                w_trig;
    logic                                w_done;

    assign w_trig  = soft_rst_req_i & ~r_req_q;
    assign rst_n_o = r_sync[SyncStages-1];

    // State register
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            r_state <= ST_WAKE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath-next logic
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt + CntWidth'(1);
        w_idx_nxt       = r_idx;
        w_rel_nxt       = r_rel;
        w_soft_pend_nxt = r_soft_pend;
        w_sync_clr      = 1'b0;
        case (r_state)
            ST_WAKE, ST_SOFT: begin
                if (((r_state == ST_WAKE) && (r_cnt == WAKE_LAST)) ||
                    ((r_state == ST_SOFT) && (r_cnt == SOFT_LAST))) begin
                    w_cnt_nxt = '0;
                    if (r_state == ST_SOFT) begin
                        w_soft_pend_nxt = 1'b1;
                    end
                    if (ALL_AT_ONCE) begin
                        w_rel_nxt   = '1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_rel_nxt[0] = 1'b1;
                        w_idx_nxt    = IdxW'(1);
                        w_state_nxt  = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                if (r_cnt == STAG_LAST) begin
                    w_cnt_nxt        = '0;
                    w_rel_nxt[r_idx] = 1'b1;
                    if (r_idx == IDX_LAST) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_idx_nxt = r_idx + IdxW'(1);
                    end
                end
            end
            default: begin
                w_cnt_nxt = r_cnt;
                // Ack consumes the pending flag on the first done cycle.
                if (r_soft_pend && w_done) begin
                    w_soft_pend_nxt = 1'b0;
                end
                if (w_trig) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_rel_nxt   = '0;
                    w_sync_clr  = 1'b1;
                    w_state_nxt = ST_SOFT;
                end
            end
        endcase
    end

    // Output logic, derived only from registered state
    always_comb begin
        phase_o        = r_state;
        w_done         = (r_state == ST_RUN) && (&rst_n_o);
        rst_done_o     = w_done;
        soft_rst_ack_o = w_done && r_soft_pend;
    end

    // Counter, release vector, request edge detect and soft-pending flag
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_rel       <= '0;
            r_req_q     <= 1'b0;
            r_soft_pend <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_rel       <= w_rel_nxt;
            r_req_q     <= soft_rst_req_i;
            r_soft_pend <= w_soft_pend_nxt;
        end
    end

    // Release synchronizers: async assert via reset_l, sync clear on soft reset
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            r_sync <= '0;
        end else if (w_sync_clr) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SyncStages-2:0], r_rel};
        end
    end

endmodule

// File: tb/tb_core_reset_sequencer.sv
// tb/tb_core_reset_sequencer.sv - directed self-checking bench for core_reset_sequencer
module tb_core_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_l;
    logic       req;
    logic       req2;
    logic       ack;
    logic       done;
    logic [2:0] rstn;
    logic [1:0] phase;
    logic       ack2;
    logic       done2;
    logic [1:0] rstn2;
    logic [1:0] phase2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    core_reset_sequencer #(
        .NumOut(3), .WakeUpCycles(8), .StaggerCycles(4),
        .SoftHoldCycles(5), .SyncStages(2), .CntWidth(16)
    ) u_dut (
        .clk_i(clk), .reset_l(reset_l), .soft_rst_req_i(req),
        .soft_rst_ack_o(ack), .rst_n_o(rstn), .rst_done_o(done), .phase_o(phase)
    );

    core_reset_sequencer #(
        .NumOut(2), .WakeUpCycles(8), .StaggerCycles(0),
        .SoftHoldCycles(5), .SyncStages(2), .CntWidth(16)
    ) u_dut_deg (
        .clk_i(clk), .reset_l(reset_l), .soft_rst_req_i(req2),
        .soft_rst_ack_o(ack2), .rst_n_o(rstn2), .rst_done_o(done2), .phase_o(phase2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all_low(input string tag);
        chk({tag, " rstn"},   32'(rstn),   32'd0);
        chk({tag, " phase"},  32'(phase),  32'd0);
        chk({tag, " done"},   32'(done),   32'd0);
        chk({tag, " ack"},    32'(ack),    32'd0);
        chk({tag, " rstn2"},  32'(rstn2),  32'd0);
        chk({tag, " phase2"}, 32'(phase2), 32'd0);
        chk({tag, " done2"},  32'(done2),  32'd0);
        chk({tag, " ack2"},   32'(ack2),   32'd0);
    endtask

    // Holds reset for a few cycles, checks the reset state, then releases
    // reset just after a falling edge so the next rising edge is edge 1.
    task automatic do_reset(input string tag);
        req     = 1'b0;
        reset_l = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_low({tag, " rst"});
        reset_l = 1'b1;
    endtask

    // Cold boot: [0] after 10, [1] after 14, [2] after 18; RELEASE@8, RUN@16.
    // Degenerate instance: both bits after 10, RUN@8.
    task automatic run_cold(input string tag, input int first, input int last);
        logic [2:0] e_rstn;
        logic [1:0] e_phase;
        for (int e = first; e <= last; e++) begin
            step();
            e_rstn  = (e >= 18) ? 3'b111 : (e >= 14) ? 3'b011 : (e >= 10) ? 3'b001 : 3'b000;
            e_phase = (e >= 16) ? 2'd2 : (e >= 8) ? 2'd1 : 2'd0;
            chk($sformatf("%s e%0d rstn", tag, e),   32'(rstn),   32'(e_rstn));
            chk($sformatf("%s e%0d phase", tag, e),  32'(phase),  32'(e_phase));
            chk($sformatf("%s e%0d done", tag, e),   32'(done),   32'(e >= 18));
            chk($sformatf("%s e%0d ack", tag, e),    32'(ack),    32'd0);
            chk($sformatf("%s e%0d rstn2", tag, e),  32'(rstn2),  (e >= 10) ? 32'd3 : 32'd0);
            chk($sformatf("%s e%0d phase2", tag, e), 32'(phase2), (e >= 8) ? 32'd2 : 32'd0);
            chk($sformatf("%s e%0d done2", tag, e),  32'(done2),  32'(e >= 10));
            chk($sformatf("%s e%0d ack2", tag, e),   32'(ack2),   32'd0);
        end
    endtask

    // Soft reset from RUN: trigger at edge E, [0]/[1]/[2] after E+7/E+11/E+15,
    // ack only in the cycle after E+15; req stays high afterwards.
    task automatic run_soft(input string tag);
        logic [2:0] e_rstn;
        logic [1:0] e_phase;
        req = 1'b1;
        step();
        chk({tag, " E rstn"},  32'(rstn),  32'd0);
        chk({tag, " E done"},  32'(done),  32'd0);
        chk({tag, " E phase"}, 32'(phase), 32'd3);
        chk({tag, " E ack"},   32'(ack),   32'd0);
        for (int k = 1; k <= 17; k++) begin
            step();
            e_rstn  = (k >= 15) ? 3'b111 : (k >= 11) ? 3'b011 : (k >= 7) ? 3'b001 : 3'b000;
            e_phase = (k >= 13) ? 2'd2 : (k >= 5) ? 2'd1 : 2'd3;
            chk($sformatf("%s E+%0d rstn", tag, k),  32'(rstn),  32'(e_rstn));
            chk($sformatf("%s E+%0d phase", tag, k), 32'(phase), 32'(e_phase));
            chk($sformatf("%s E+%0d done", tag, k),  32'(done),  32'(k >= 15));
            chk($sformatf("%s E+%0d ack", tag, k),   32'(ack),   32'(k == 15));
        end
        for (int k = 18; k <= 25; k++) begin
            step();
            chk($sformatf("%s hold E+%0d ack", tag, k),   32'(ack),   32'd0);
            chk($sformatf("%s hold E+%0d phase", tag, k), 32'(phase), 32'd2);
            chk($sformatf("%s hold E+%0d rstn", tag, k),  32'(rstn),  32'd7);
        end
    endtask

    initial begin
        reset_l = 1'b0;
        req     = 1'b0;
        req2    = 1'b0;

        do_reset("cold");
        run_cold("cold", 1, 20);
        run_soft("soft");
        req = 1'b0;
        step();

        do_reset("ign");
        run_cold("ign", 1, 4);
        req = 1'b1;
        run_cold("ign", 5, 20);
        req = 1'b0;
        step();
        run_soft("ign_soft");
        req = 1'b0;
        step();

        do_reset("mid");
        run_cold("mid", 1, 13);
        chk("mid e13 rstn", 32'(rstn), 32'd1);
        reset_l = 1'b0;
        #1;
        chk_all_low("mid async");
        do_reset("mid2");
        run_cold("mid2", 1, 20);

        req = 1'b1;
        step();
        step();
        step();
        reset_l = 1'b0;
        #1;
        chk_all_low("softabort async");
        do_reset("softabort");
        run_cold("softabort", 1, 20);
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("softabort tail%0d ack", k),  32'(ack),  32'd0);
            chk($sformatf("softabort tail%0d done", k), 32'(done), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
